// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   NOP_INSTR        : encoding presented on the instruction output when the queue is empty
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_state_e    : fetch controller states (RUN fetches, DRAIN swallows killed responses)
//   word_align       : clears the byte-offset bits of an address
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Bundle of every non-clock signal of the instruction fetch queue.
//   imem_*    : request/grant/response channel to instruction memory
//   redirect_*: branch/jump redirect from execute
//   instr_*   : queue head toward the IF/ID register, pc_o is its address
// Modport master is the fetch queue side, slave is the environment side
// (memory, execute and decode together).
interface instruction_fetch_queue_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i, instr_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used both for the instruction queue and for the
// in-flight fetch PC queue.
//   clk, reset : clock, asynchronous active-low reset
//   flush      : empties the FIFO, overriding any same-cycle write/read
//   wr_en/wr_data : push (ignored when full unless a read frees a slot)
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : head entry, valid whenever count != 0
//   count      : number of stored entries
// The head is selected from the register array by a registered read
// pointer, so rd_data and count depend on flops only; a written entry
// becomes visible the cycle after the write.  DEPTH need not be a power
// of two: pointers wrap explicitly.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_rd = rd_en && (count_reg != '0);
    // A pop in the same cycle frees a slot, so push+pop is legal when full.
    assign do_wr = wr_en && ((count_reg != CNT_W'(DEPTH)) || do_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_rd) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues word fetches to instruction memory,
// tracks the addresses of granted-but-unanswered requests, and buffers
// returned instructions for decode.
//   clk       : single clock, rising edge
//   reset     : asynchronous active-low reset
//   fetch_bus : master side of instruction_fetch_queue_if
// Parameters: DEPTH (queue entries), RESET_PC (first fetch address),
// MAX_OUTSTANDING (granted requests awaiting response).
// A request is only issued when the queue is guaranteed to have room for
// its response (occupancy + outstanding < DEPTH), so the queue can never
// overflow.  A redirect flushes everything; responses to requests that
// were already granted are swallowed in DRAIN by counting them down.
module instruction_fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic                       clk,
    input logic                       reset,
    instruction_fetch_queue_if.master fetch_bus
);

    localparam int QCNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e     state_reg;
    fetch_state_e     state_next;
    logic [31:0]      fetch_pc_reg;
    logic [31:0]      fetch_pc_next;
    logic [OUT_W-1:0] kill_cnt_reg;
    logic [OUT_W-1:0] kill_cnt_next;
    logic [OUT_W-1:0] killed_run;

    logic [QCNT_W-1:0] q_count;
    logic [63:0]       q_head;
    logic [OUT_W-1:0]  out_count;
    logic [31:0]       inflight_pc;

    logic credit_ok;
    logic req_int;
    logic accepting;
    logic gnt_fire;
    logic resp_take;
    logic head_valid;
    logic q_pop;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RUN;
            fetch_pc_reg <= word_align(RESET_PC);
            kill_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            kill_cnt_reg <= kill_cnt_next;
        end
    end

    // Requests killed by a redirect in RUN: everything outstanding plus a
    // same-cycle grant, minus a same-cycle response (which retires one).
    always_comb begin
        killed_run = out_count + OUT_W'(gnt_fire);
        if (fetch_bus.imem_rvalid_i && (killed_run != '0)) begin
            killed_run = killed_run - OUT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        kill_cnt_next = kill_cnt_reg;
        fetch_pc_next = fetch_pc_reg;

        if (gnt_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (fetch_bus.redirect_i) begin
            fetch_pc_next = word_align(fetch_bus.redirect_pc_i);
        end

        case (state_reg)
            RUN: begin
                if (fetch_bus.redirect_i) begin
                    kill_cnt_next = killed_run;
                    state_next    = (killed_run != '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (fetch_bus.imem_rvalid_i && (kill_cnt_reg != '0)) begin
                    kill_cnt_next = kill_cnt_reg - OUT_W'(1);
                end
                // Leave one cycle after the count has reached zero; a new
                // redirect only retargets the PC and keeps us here.
                if (!fetch_bus.redirect_i && (kill_cnt_reg == '0)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    assign credit_ok = ((int'(q_count) + int'(out_count)) < DEPTH) &&
                       (int'(out_count) < MAX_OUTSTANDING);

    always_comb begin
        req_int   = 1'b0;
        accepting = 1'b0;
        case (state_reg)
            RUN: begin
                req_int   = credit_ok;
                accepting = !fetch_bus.redirect_i;
            end
            default: begin
                req_int   = 1'b0;
                accepting = 1'b0;
            end
        endcase
    end

    // Reset gates the request directly so it is low for the whole reset
    // period and high in the very first cycle after release.
    assign fetch_bus.imem_req_o  = req_int && reset;
    assign fetch_bus.imem_addr_o = fetch_pc_reg;

    assign gnt_fire  = fetch_bus.imem_req_o && fetch_bus.imem_gnt_i;
    assign resp_take = fetch_bus.imem_rvalid_i && accepting;
    assign q_pop     = head_valid && fetch_bus.instr_ready_i && !fetch_bus.redirect_i;

    // In-flight PC queue: one entry per granted request, popped by its response.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_inflight_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fetch_bus.redirect_i),
        .wr_en   (gnt_fire && accepting),
        .wr_data (fetch_pc_reg),
        .rd_en   (resp_take),
        .rd_data (inflight_pc),
        .count   (out_count)
    );

    // Instruction queue: entries are {pc, instruction}.
    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fetch_bus.redirect_i),
        .wr_en   (resp_take),
        .wr_data ({inflight_pc, fetch_bus.imem_rdata_i}),
        .rd_en   (q_pop),
        .rd_data (q_head),
        .count   (q_count)
    );

    assign head_valid              = (q_count != '0);
    assign fetch_bus.instr_valid_o = head_valid;
    assign fetch_bus.instr_o       = head_valid ? q_head[31:0]  : NOP_INSTR;
    assign fetch_bus.pc_o          = head_valid ? q_head[63:32] : 32'h0;

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000: first fetch address after reset.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2: maximum granted requests awaiting response.
REQ-004 SHALL provide clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL provide imem_req_o, output, 1: fetch request valid.
REQ-007 SHALL provide imem_addr_o, output, 32: fetch address, word aligned.
REQ-008 SHALL provide imem_gnt_i, input, 1: request accepted this cycle.
REQ-009 SHALL provide imem_rvalid_i, input, 1: response valid; responses return in order, at least 1 cycle after their grant.
REQ-010 SHALL provide imem_rdata_i, input, 32: instruction word.
REQ-011 SHALL provide redirect_i, input, 1: taken branch or jump from the execute stage.
REQ-012 SHALL provide redirect_pc_i, input, 32: target address.
REQ-013 SHALL provide instr_valid_o, output, 1: queue head valid toward the IF/ID register.
REQ-014 SHALL provide instr_o, output, 32: head instruction.
REQ-015 SHALL provide pc_o, output, 32: head instruction address.
REQ-016 SHALL provide instr_ready_i, input, 1: decode accepts the head; low means stall.

Function
REQ-017 SHALL assert imem_req_o in state RUN when (occupancy + outstanding) < DEPTH and outstanding < MAX_OUTSTANDING.
REQ-018 SHALL hold imem_addr_o stable while imem_req_o=1 and imem_gnt_i=0; the only exception is a redirect.
REQ-019 SHALL, on grant, push the fetch PC into an in-flight PC queue, increment outstanding, and advance the fetch PC by 4, wrapping modulo 2^32.
REQ-020 SHALL, on imem_rvalid_i in RUN, write {in-flight PC, imem_rdata_i} into the queue and decrement outstanding.
REQ-021 SHALL make a written entry visible on instr_valid_o the cycle after rvalid, with no bypass.
REQ-022 SHALL pop the head when instr_valid_o=1 and instr_ready_i=1; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-023 SHALL drive instr_o=32'h0000_0013 (NOP) and pc_o=0 whenever instr_valid_o=0.
REQ-024 SHALL never overflow the queue; the credit rule in REQ-017 guarantees this without a full check.
REQ-025 SHALL, on redirect_i, do all of the following in that cycle: flush the queue; set the fetch PC to {redirect_pc_i[31:2],2'b00}; ignore any same-cycle pop; treat any same-cycle grant as a killed request.
REQ-026 SHALL enter state DRAIN on redirect if the killed outstanding count, including a same-cycle grant and excluding a same-cycle rvalid, is nonzero; otherwise it SHALL stay in RUN.
REQ-027 SHALL, in DRAIN, hold imem_req_o=0, discard every rvalid, decrement the kill count, and return to RUN in the cycle after the count reaches 0.
REQ-028 SHALL, on a redirect during DRAIN, update the fetch PC and remain in DRAIN.
REQ-029 SHALL drive instr_valid_o=0 the cycle after any redirect.

Reset
REQ-030 SHALL, while reset=0, force: fetch PC=RESET_PC, queue empty, outstanding=0, state RUN, imem_req_o=0, instr_valid_o=0, instr_o=NOP, pc_o=0.
REQ-031 SHALL assert imem_req_o with imem_addr_o=RESET_PC in the first cycle after reset deasserts.
REQ-032 SHALL, when reset is asserted mid-transaction, drop all in-flight and queued state; responses arriving after release that belong to pre-reset requests are the environment's responsibility.

Structure
REQ-033 SHALL take the NOP constant, the default RESET_PC, and the state enum {RUN, DRAIN} from shared package riscv_fetch_pkg.
REQ-034 SHALL implement the instruction queue as sub-module fetch_fifo (parameterised width/depth, synchronous FIFO, registered outputs); the in-flight PC queue SHALL reuse the same sub-module.

Verification
REQ-035 Zero-wait memory (gnt=1, rvalid the following cycle), ready=1 -> pc_o sequence 0x00400000, 0x00400004, ... consecutively; first valid 3 cycles after reset release.
REQ-036 ready=0 for 10 cycles -> exactly 4 entries queued, imem_req_o low, no loss; on ready=1 the 4 entries drain in order.
REQ-037 Redirect to 0x00400103 with 2 outstanding -> DRAIN, both responses discarded, next request address 0x00400100, no stale instr_valid_o.
REQ-038 Redirect coincident with grant and rvalid -> the granted request is killed, the rvalid entry is dropped, and the kill count equals the remaining outstanding requests.
REQ-039 Fetch PC at 0xFFFFFFFC -> next request address 0x00000000.
REQ-040 Reset asserted while in DRAIN -> all outputs take their reset values asynchronously, and the first request after release is RESET_PC.
